// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic MARK      = 1'b1;
  localparam logic SPACE     = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..D-1 while enabled and pulses bit_done on the
// last cycle of each serial bit. A clear restarts the period at 0 so a new
// frame always begins with a full-length start bit.
module uart_baud_cnt #(
  parameter int D = 434,
  parameter int L = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_done
);

  localparam logic [L-1:0] LAST = L'(D - 1);

  logic [L-1:0] cnt;

  assign bit_done = en && (cnt == LAST);

  // Period counter, wraps at each bit boundary and idles at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_done ? '0 : cnt + L'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, 8N1, LSB first, D clock cycles per bit.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// data bit 7 and the stop bit (frame grows from 10*D to 11*D cycles).
// Both serial outputs are registered; the FSM computes their next values.
module uart_tx
  import uart_pkg::*;
#(
  parameter int D = 434,
  parameter int L = 9
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_we,
  output logic       o_data,
  output logic       o_busy
);

  state_t                 state, state_nxt;
  logic [DATA_BITS-1:0]   shreg, shreg_nxt;
  logic [2:0]             idx, idx_nxt;
  logic                   data_nxt, busy_nxt;
  logic                   accept;
  logic                   bit_done;
`ifdef UART_TX_PARITY_EN
  logic                   par, par_nxt;
`endif

  uart_baud_cnt #(.D(D), .L(L)) u_baud (
    .clk      (i_clk),
    .rst      (i_rst),
    .clr      (accept),
    .en       (state != IDLE),
    .bit_done (bit_done)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus next values of the line, busy flag and shift datapath.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    data_nxt  = o_data;
    busy_nxt  = o_busy;
    accept    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: begin
        data_nxt = MARK;
        busy_nxt = 1'b0;
        if (i_we) begin
          accept    = 1'b1;
          state_nxt = START;
          shreg_nxt = i_data;
          idx_nxt   = 3'd0;
          data_nxt  = SPACE;
          busy_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^i_data;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt = DATA;
          data_nxt  = shreg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            data_nxt  = par;
`else
            state_nxt = STOP;
            data_nxt  = MARK;
`endif
          end else begin
            // Shift right so the next bit to send always sits at shreg[0].
            idx_nxt   = idx + 3'd1;
            shreg_nxt = {1'b0, shreg[DATA_BITS-1:1]};
            data_nxt  = shreg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          data_nxt  = MARK;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_nxt = IDLE;
          data_nxt  = MARK;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        data_nxt  = MARK;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Registered outputs and shift datapath; reset returns the line to mark.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data <= MARK;
      o_busy <= 1'b0;
      shreg  <= '0;
      idx    <= 3'd0;
`ifdef UART_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      o_data <= data_nxt;
      o_busy <= busy_nxt;
      shreg  <= shreg_nxt;
      idx    <= idx_nxt;
`ifdef UART_TX_PARITY_EN
      par    <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with D=10, L=4, 20 ns clock.
// Frames are given as hand-written bit tables, index 0 = start bit.
module tb_uart_tx;

  localparam int D = 10;
  localparam int L = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] F41 = 11'b10010000010;
  localparam logic [10:0] F55 = 11'b10010101010;
  localparam logic [10:0] FA3 = 11'b10101000110;
  localparam logic [10:0] F01 = 11'b11000000010;
`else
  localparam int NB = 10;
  localparam logic [10:0] F41 = 11'b01010000010;
  localparam logic [10:0] F55 = 11'b01010101010;
  localparam logic [10:0] FA3 = 11'b01101000110;
  localparam logic [10:0] F01 = 11'b01000000010;
`endif
  localparam int CYC = NB * D;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_we;
  logic       o_data;
  logic       o_busy;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx #(.D(D), .L(L)) dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .i_we   (i_we),
    .o_data (o_data),
    .o_busy (o_busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while idle: next posedge accepts the byte.
  task automatic accept_now(input logic [7:0] b);
    i_data = b;
    i_we   = 1'b1;
    @(posedge clk);
    #1;
    i_we   = 1'b0;
  endtask

  // Checks the line each cycle against the table, decodes mid-bit, and
  // optionally injects a write (data 0xFF) while busy at cycle inject_at.
  task automatic check_frame(input logic [7:0] b, input logic [10:0] f, input int inject_at);
    int         busy_cnt;
    int         k;
    logic [7:0] rx;
    busy_cnt = 0;
    rx       = 8'h00;
    for (int n = 0; n < CYC; n++) begin
      @(negedge clk);
      k = n / D;
      check($sformatf("line_%02h_bit%0d_cyc%0d", b, k, n % D), {31'b0, o_data}, {31'b0, f[k]});
      if (o_busy) busy_cnt++;
      if ((n % D) == D / 2 && k >= 1 && k <= 8) rx[k-1] = o_data;
      if (inject_at >= 0) begin
        if (n == inject_at) begin
          i_we   = 1'b1;
          i_data = 8'hFF;
        end else if (n == inject_at + 1) begin
          i_we   = 1'b0;
        end
      end
    end
    check($sformatf("rx_byte_%02h", b), {24'b0, rx}, {24'b0, b});
    check($sformatf("busy_cycles_%02h", b), busy_cnt, CYC);
    @(negedge clk);
    check($sformatf("busy_end_%02h", b), {31'b0, o_busy}, 32'd0);
    check($sformatf("line_end_%02h", b), {31'b0, o_data}, 32'd1);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      check({tag, "_line"}, {31'b0, o_data}, 32'd1);
      check({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
    end
  endtask

  initial begin
    i_rst  = 1'b1;
    i_we   = 1'b0;
    i_data = 8'h00;

    // Reset asserted, then released at 30 ns.
    #5;
    check("rst_line_a", {31'b0, o_data}, 32'd1);
    check("rst_busy_a", {31'b0, o_busy}, 32'd0);
    #20;
    check("rst_line_b", {31'b0, o_data}, 32'd1);
    check("rst_busy_b", {31'b0, o_busy}, 32'd0);
    #5;
    i_rst = 1'b0;
    check_idle("post_rst", 3);

    // Single byte 0x41.
    accept_now(8'h41);
    check_frame(8'h41, F41, -1);
    check_idle("after_41", 4);

    // Write while busy is ignored; i_data changes do not disturb the frame.
    accept_now(8'h41);
    check_frame(8'h41, F41, 30);
    check_idle("after_ign", 4);

    // Back-to-back: second write on the first non-busy cycle.
    accept_now(8'h55);
    check_frame(8'h55, F55, -1);
    accept_now(8'hA3);
    check_frame(8'hA3, FA3, -1);
    check_idle("after_b2b", 3);

    // Mid-frame reset during data bit 3 of 0x00.
    accept_now(8'h00);
    repeat (4 * D + 4) @(negedge clk);
    check("pre_rst_line", {31'b0, o_data}, 32'd0);
    check("pre_rst_busy", {31'b0, o_busy}, 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_rst_line", {31'b0, o_data}, 32'd1);
    check("mid_rst_busy", {31'b0, o_busy}, 32'd0);
    @(negedge clk);
    i_rst = 1'b0;
    check_idle("after_mid_rst", 3);
    accept_now(8'h01);
    check_frame(8'h01, F01, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-wide asynchronous serial transmitter (UART TX), 8N1 framing, LSB first.
- Sits between a local write port (data + write strobe) and the serial TX pin.
- Bit period set by parameter D in clock cycles.
- o_busy signals the upstream writer when a new byte may be accepted.

Parameters:
- D, 434, clock cycles per serial bit (e.g. 50 MHz / 115200); must be >= 2.
- L, 9, width of the bit-period counter; must satisfy 2^L >= D.

Ports:
- i_clk  in  1  system clock, rising-edge active.
- i_rst  in  1  asynchronous, active-high reset.
- i_data  in  8  byte to transmit; sampled only on an accepted write.
- i_we  in  1  write strobe; one-cycle pulse requests transmission of i_data.
- o_data  out  1  serial TX line; idle/mark = 1.
- o_busy  out  1  1 while a frame is in progress.

Behaviour:
- Reset (async, immediate): o_data=1, o_busy=0, state IDLE, counters cleared, shift register cleared; reset mid-frame aborts the frame with the line high.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, STOP (, PARITY with the option below).
- IDLE: o_data=1, o_busy=0.
- Acceptance: at a rising edge with i_we=1 in IDLE, i_data is latched. On that same edge o_data becomes 0 (start bit), o_busy becomes 1, and state goes to START.
- START: hold 0 for D cycles, then go to DATA.
- DATA: send latched bits 0..7, LSB first, each held D cycles; a 3-bit index counts bits and after bit 7 the FSM goes to STOP.
- STOP: hold 1 for D cycles, then go to IDLE; o_busy drops on the edge ending the stop bit.
- Frame timing: o_busy is high exactly 10*D cycles (11*D with parity).
- Bit-period counter (L bits): counts 0..D-1, wraps to 0 at each bit boundary, reset to 0 on acceptance.
- i_we while o_busy=1 is ignored: no queuing, latched data unaffected.
- i_data changes after acceptance do not affect the current frame.
- Back-to-back: i_we on the first cycle o_busy=0 is accepted; there is no extra idle gap beyond the stop bit.
- i_we held high continuously: a new frame starts on each IDLE cycle.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and the stop bit, held D cycles. Frame becomes 11*D cycles.
- Undefined: no PARITY state, plain 8N1, 10*D-cycle frame.
- Port list is identical in both builds.

Decomposition:
- Package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP), constant DATA_BITS=8, line-level constants MARK=1 / SPACE=0.
- One natural sub-module: uart_baud_cnt.
  - L-bit counter producing a one-cycle bit_done pulse at count D-1.
  - Has a sync clear input driven on frame acceptance.
  - uart_tx holds the FSM, shift register and bit index.

Test Plan (D=10, L=4, 20 ns clock):
- Reset: i_rst=1 for 30 ns -> o_data=1, o_busy=0 throughout reset and after release while i_we=0.
- Single byte: i_data=0x41, i_we pulse 1 cycle -> starting with the accepting edge, o_data is 0 (start bit), then 1,0,0,0,0,0,1,0, then 1 (stop), 10 cycles each. o_busy is high for exactly 100 cycles, then o_data stays 1.
- Ignored write: during the 0x41 frame, pulse i_we with i_data=0xFF -> waveform identical to the single-byte case, no second frame.
- Back-to-back: 0x55 then 0xA3, with the second i_we on the first cycle o_busy=0 -> two contiguous frames, 200 busy cycles total with at most one idle cycle between, both bytes decoded correctly by a bench receiver sampling mid-bit.
- Mid-frame reset: assert i_rst during data bit 3 of 0x00 -> o_data=1 and o_busy=0 immediately (async); the next i_we after release starts a complete fresh frame.
- Parity build (UART_TX_PARITY_EN): i_data=0x41 -> parity bit 0 after bit 7; i_data=0x01 -> parity bit 1; o_busy high for 110 cycles.
